// File: rtl/bip_pkg.sv
// Shared constants for the BIP sequencer: command encodings, FSM state
// encodings and the HLT opcode used to terminate a program load.
package bip_pkg;

  localparam int unsigned OPC_WIDTH = 5;
  localparam int unsigned CMD_WIDTH = 2;
  localparam int unsigned ST_WIDTH  = 3;

  // Host command encodings
  localparam logic [CMD_WIDTH-1:0] CMD_LOAD  = 2'b00;
  localparam logic [CMD_WIDTH-1:0] CMD_RUN   = 2'b01;
  localparam logic [CMD_WIDTH-1:0] CMD_STEP  = 2'b10;
  localparam logic [CMD_WIDTH-1:0] CMD_CLEAR = 2'b11;

  // Sequencer state encodings (visible on o_state)
  localparam logic [ST_WIDTH-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_WIDTH-1:0] ST_LOAD   = 3'd1;
  localparam logic [ST_WIDTH-1:0] ST_RUN    = 3'd2;
  localparam logic [ST_WIDTH-1:0] ST_STEP   = 3'd3;
  localparam logic [ST_WIDTH-1:0] ST_HALTED = 3'd4;

  // Opcode that ends a program image
  localparam logic [OPC_WIDTH-1:0] OPC_HLT = 5'b00000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable
//   clr        : synchronous clear (wins over en)
//   count      : current value, sticks at all-ones
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bip_sequencer.sv
// Control sequencer for a small BIP CPU: loads a program image into
// instruction memory, then runs or single-steps the CPU until it halts.
//   i_clk, i_rst_n                      : clock, async active-low reset
//   i_cmd_valid, i_cmd, o_cmd_ready     : host command handshake
//   i_rx_valid, i_rx_data, o_rx_ready   : program-word stream
//   o_imem_we, o_imem_addr, o_imem_data : instruction-memory write port
//   i_halt                              : decoder halt flag
//   o_cpu_en, o_cpu_clr                 : CPU enable / one-cycle clear
//   o_state, o_cycles, o_prog_len, o_done : status
module bip_sequencer
  import bip_pkg::*;
#(
  parameter int unsigned INST_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned CYC_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  input  logic [1:0]            i_cmd,
  output logic                  o_cmd_ready,
  input  logic                  i_rx_valid,
  input  logic [INST_WIDTH-1:0] i_rx_data,
  output logic                  o_rx_ready,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [INST_WIDTH-1:0] o_imem_data,
  input  logic                  i_halt,
  output logic                  o_cpu_en,
  output logic                  o_cpu_clr,
  output logic [2:0]            o_state,
  output logic [CYC_WIDTH-1:0]  o_cycles,
  output logic [ADDR_WIDTH:0]   o_prog_len,
  output logic                  o_done
);

  localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;

  logic [ST_WIDTH-1:0]   state;
  logic [ST_WIDTH-1:0]   next_state;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  cmd_fire;
  logic                  rx_fire;
  logic                  last_word;
  logic                  load_cmd;
  logic                  clear_cmd;

  // Handshake and status decode from the state register
  assign o_cmd_ready = (state == ST_IDLE) || (state == ST_HALTED);
  assign o_rx_ready  = (state == ST_LOAD);
  assign cmd_fire    = i_cmd_valid && o_cmd_ready;
  assign rx_fire     = i_rx_valid && o_rx_ready;
  assign o_imem_addr = waddr;
  assign o_imem_data = i_rx_data;
  assign o_state     = state;

  // Load ends on an HLT word or on the last addressable slot
  assign last_word = (i_rx_data[INST_WIDTH-1 -: OPC_WIDTH] == OPC_HLT) ||
                     (waddr == {ADDR_WIDTH{1'b1}});

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and combinational outputs
  always_comb begin
    next_state = state;
    o_cpu_en   = 1'b0;
    o_imem_we  = 1'b0;
    load_cmd   = 1'b0;
    clear_cmd  = 1'b0;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (cmd_fire) begin
          case (i_cmd)
            CMD_LOAD: begin
              load_cmd   = 1'b1;
              next_state = ST_LOAD;
            end
            // RUN/STEP are accepted but ignored once halted
            CMD_RUN:  if (state == ST_IDLE) next_state = ST_RUN;
            CMD_STEP: if (state == ST_IDLE) next_state = ST_STEP;
            default: begin
              clear_cmd  = 1'b1;
              next_state = ST_IDLE;
            end
          endcase
        end
      end
      ST_LOAD: begin
        o_imem_we = rx_fire;
        if (rx_fire && last_word) next_state = ST_IDLE;
      end
      ST_RUN: begin
        o_cpu_en = !i_halt;
        if (i_halt) next_state = ST_HALTED;
      end
      ST_STEP: begin
        o_cpu_en   = !i_halt;
        next_state = i_halt ? ST_HALTED : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Load address, program length, clear and done pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      waddr      <= '0;
      o_prog_len <= '0;
      o_cpu_clr  <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_cpu_clr <= load_cmd || clear_cmd;
      o_done    <= (next_state == ST_HALTED) && (state != ST_HALTED);
      if (load_cmd) begin
        waddr      <= '0;
        o_prog_len <= '0;
      end else if (o_imem_we) begin
        o_prog_len <= o_prog_len + LEN_WIDTH'(1);
        // Hold at the top slot rather than wrap
        if (waddr != {ADDR_WIDTH{1'b1}}) waddr <= waddr + ADDR_WIDTH'(1);
      end
    end
  end

  // Executed-cycle counter
  sat_counter #(
    .WIDTH (CYC_WIDTH)
  ) u_cycles (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (o_cpu_en),
    .clr   (clear_cmd),
    .count (o_cycles)
  );

endmodule

// File: doc/bip_sequencer.md
BIP_SEQUENCER -- requirements
Module: bip_sequencer

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 16, meaning instruction word width (5-bit opcode in MSBs, operand in the remaining bits).
REQ-002 SHALL have parameter ADDR_WIDTH, default 11, meaning instruction-memory address width.
REQ-003 SHALL have parameter CYC_WIDTH, default 32, meaning executed-cycle counter width.
REQ-004 SHALL have port i_clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port i_cmd_valid, input, 1, meaning a command is offered.
REQ-007 SHALL have port i_cmd, input, 2, meaning the command: 00 LOAD, 01 RUN, 10 STEP, 11 CLEAR.
REQ-008 SHALL have port o_cmd_ready, output, 1, meaning a command can be accepted; high only in IDLE and HALTED.
REQ-009 SHALL have ports i_rx_valid (input, 1), i_rx_data (input, INST_WIDTH) and o_rx_ready (output, 1), meaning the program-word stream.
REQ-010 SHALL have ports o_imem_we (output, 1), o_imem_addr (output, ADDR_WIDTH) and o_imem_data (output, INST_WIDTH), meaning the instruction-memory write port.
REQ-011 SHALL have port i_halt, input, 1, meaning the decoder halt flag for the current instruction.
REQ-012 SHALL have port o_cpu_en, output, 1, meaning the PC/accumulator/RAM write enable for the CPU.
REQ-013 SHALL have port o_cpu_clr, output, 1, meaning a one-cycle synchronous clear of the CPU PC and accumulator.
REQ-014 SHALL have ports o_state (output, 3), o_cycles (output, CYC_WIDTH), o_prog_len (output, ADDR_WIDTH+1) and o_done (output, 1), meaning status outputs.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, RUN, STEP and HALTED; o_state SHALL carry the state encoding.
REQ-016 SHALL accept a command only when i_cmd_valid and o_cmd_ready are high in the same cycle.
REQ-017 SHALL handle accepted commands as follows:
  - LOAD: clear the write address and o_prog_len, pulse o_cpu_clr, go to LOAD.
  - RUN: go to RUN.
  - STEP: go to STEP.
  - CLEAR: pulse o_cpu_clr, zero o_cycles, go to IDLE.
REQ-018 SHALL hold o_rx_ready high only in LOAD.
REQ-019 SHALL, on each rx handshake in LOAD, assert o_imem_we for that same cycle with o_imem_addr equal to the current address and o_imem_data equal to i_rx_data, then increment the address and o_prog_len.
REQ-020 SHALL leave LOAD for IDLE after writing a word whose opcode is 00000 (HLT) or a word at address 2^ADDR_WIDTH-1; the address SHALL never wrap, and o_prog_len SHALL then equal the number of words written.
REQ-021 SHALL, in RUN, drive o_cpu_en = !i_halt combinationally, and move to HALTED on the cycle after i_halt is seen high.
REQ-022 SHALL, in STEP, drive o_cpu_en = !i_halt for exactly one cycle, then go to IDLE, or to HALTED if i_halt was high.
REQ-023 SHALL pulse o_done high for one cycle on every entry to HALTED.
REQ-024 SHALL increment o_cycles on each cycle with o_cpu_en high, saturating at all-ones.
REQ-025 SHALL, in HALTED, treat RUN and STEP as accepted no-ops; only LOAD or CLEAR leave HALTED.
REQ-026 SHALL drive o_cpu_en, o_imem_we and o_cpu_clr low in IDLE, HALTED and LOAD, except the o_cpu_clr pulses defined above.

Reset
REQ-027 SHALL, while i_rst_n is low, force state IDLE and set o_cycles, o_prog_len, the write address, o_done, o_cpu_en, o_imem_we and o_cpu_clr to 0, and o_cmd_ready to 1; a mid-LOAD reset SHALL keep o_prog_len at 0.

Structure
REQ-028 SHALL place the command encodings, the state enumeration and the HLT opcode constant 5'b00000 in the shared package bip_pkg.
REQ-029 SHALL implement o_cycles in one sub-module, sat_counter (enable, synchronous clear, saturate at all-ones).

Verification
REQ-030 SHALL cover: LOAD, then words 0x1805, 0x2803, 0x0000 -> three writes at addresses 0,1,2, o_prog_len=3, state IDLE.
REQ-031 SHALL cover: RUN with i_halt rising on the 4th enabled cycle -> o_cycles=3, one-cycle o_done, state HALTED.
REQ-032 SHALL cover: STEP issued three times from IDLE with i_halt low -> exactly three single-cycle o_cpu_en pulses, o_cycles=3.
REQ-033 SHALL cover: with ADDR_WIDTH=2, load 5 non-HLT words -> four writes, o_prog_len=4, o_rx_ready low afterwards, 5th word never accepted.
REQ-034 SHALL cover: i_rst_n low during LOAD after 2 words -> IDLE, o_prog_len=0; CLEAR from HALTED -> o_cpu_clr pulse, o_cycles=0.
